// File: rtl/alu32_arbiter_if.sv
//------------------------------------------------------------------------------
// Module      : alu32_arbiter_if
// Description : Handshake/bus bundle between the two issuing units, the
//               shared ALU32 sequencer and the result consumer.
//               The res_zero wire exists only when ALU32_ARB_ZERO_FLAG_EN
//               is defined.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface alu32_arbiter_if #(
  parameter int WIDTH = 32
);
  // Requester A
  logic             a_valid;
  logic             a_ready;
  logic [1:0]       a_op;
  logic [WIDTH-1:0] a_in1;
  logic [WIDTH-1:0] a_in2;
  // Requester B
  logic             b_valid;
  logic             b_ready;
  logic [1:0]       b_op;
  logic [WIDTH-1:0] b_in1;
  logic [WIDTH-1:0] b_in2;
  // Result side
  logic             res_valid;
  logic             res_ready;
  logic             res_id;
  logic [WIDTH-1:0] res_data;
  logic             busy;
`ifdef ALU32_ARB_ZERO_FLAG_EN
  logic             res_zero;
`endif

`ifdef ALU32_ARB_ZERO_FLAG_EN
  // Requesters and consumer side
  modport master (
    output a_valid, a_op, a_in1, a_in2,
    output b_valid, b_op, b_in1, b_in2,
    output res_ready,
    input  a_ready, b_ready, res_valid, res_id, res_data, busy, res_zero
  );
  // Arbiter side
  modport slave (
    input  a_valid, a_op, a_in1, a_in2,
    input  b_valid, b_op, b_in1, b_in2,
    input  res_ready,
    output a_ready, b_ready, res_valid, res_id, res_data, busy, res_zero
  );
`else
  modport master (
    output a_valid, a_op, a_in1, a_in2,
    output b_valid, b_op, b_in1, b_in2,
    output res_ready,
    input  a_ready, b_ready, res_valid, res_id, res_data, busy
  );
  modport slave (
    input  a_valid, a_op, a_in1, a_in2,
    input  b_valid, b_op, b_in1, b_in2,
    input  res_ready,
    output a_ready, b_ready, res_valid, res_id, res_data, busy
  );
`endif

endinterface

`default_nettype wire

// File: rtl/alu32_arbiter.sv
//------------------------------------------------------------------------------
// Module      : alu32_arbiter
// Description : Round-robin arbiter/sequencer sharing one 32-bit ALU
//               (AND/OR/XOR/ADD) between requesters A and B. One operation
//               in flight: IDLE (grant) -> EXEC (compute) -> DONE (hold
//               tagged result until accepted).
//               Optional macro ALU32_ARB_ZERO_FLAG_EN adds the registered
//               res_zero flag.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module alu32_arbiter #(
  parameter int WIDTH = 32  // ALU slices are 32-bit; only 32 is supported
) (
  input  logic               clk,
  input  logic               rst,
  alu32_arbiter_if.slave     bus
);

  localparam logic [1:0] C_OP_AND = 2'b00;
  localparam logic [1:0] C_OP_OR  = 2'b01;
  localparam logic [1:0] C_OP_XOR = 2'b10;
  localparam logic [1:0] C_OP_ADD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_last_grant;   // 0 = A, 1 = B; updated at result acceptance
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_in1;
  logic [WIDTH-1:0] r_in2;
  logic             r_id;
  logic             r_res_valid;
  logic             r_res_id;
  logic [WIDTH-1:0] r_res_data;
  logic             r_busy;
`ifdef ALU32_ARB_ZERO_FLAG_EN
  logic             r_res_zero;
`endif

  logic             w_grant_id;
  logic             w_idle;
  logic             w_a_ready;
  logic             w_b_ready;
  logic             w_accept;
  logic [WIDTH-1:0] w_alu;

  // Round-robin pick: a lone requester wins, a tie goes to the one not served last
  always_comb begin
    w_grant_id = 1'b0;
    if (bus.a_valid && bus.b_valid) begin
      w_grant_id = ~r_last_grant;
    end else if (bus.b_valid) begin
      w_grant_id = 1'b1;
    end
  end

  // Ready is suppressed during reset so a handshake can never coincide with it
  assign w_idle    = (r_state == ST_IDLE) && !rst;
  assign w_a_ready = w_idle && bus.a_valid && (w_grant_id == 1'b0);
  assign w_b_ready = w_idle && bus.b_valid && (w_grant_id == 1'b1);
  assign w_accept  = w_a_ready || w_b_ready;

  // Shared ALU datapath operating on the latched operands only
  always_comb begin
    w_alu = '0;
    case (r_op)
      C_OP_AND: w_alu = r_in1 & r_in2;
      C_OP_OR:  w_alu = r_in1 | r_in2;
      C_OP_XOR: w_alu = r_in1 ^ r_in2;
      C_OP_ADD: w_alu = r_in1 + r_in2;  // carry-out intentionally dropped
      default:  w_alu = '0;
    endcase
  end

  // Sequencer FSM with registered result/status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;           // B counts as last served, so A wins the first tie
      r_op         <= C_OP_AND;
      r_in1        <= '0;
      r_in2        <= '0;
      r_id         <= 1'b0;
      r_res_valid  <= 1'b0;
      r_res_id     <= 1'b0;
      r_res_data   <= '0;
      r_busy       <= 1'b0;
`ifdef ALU32_ARB_ZERO_FLAG_EN
      r_res_zero   <= 1'b1;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op    <= w_grant_id ? bus.b_op  : bus.a_op;
            r_in1   <= w_grant_id ? bus.b_in1 : bus.a_in1;
            r_in2   <= w_grant_id ? bus.b_in2 : bus.a_in2;
            r_id    <= w_grant_id;
            r_busy  <= 1'b1;
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_res_data  <= w_alu;
          r_res_id    <= r_id;
`ifdef ALU32_ARB_ZERO_FLAG_EN
          r_res_zero  <= (w_alu == '0);
`endif
          r_res_valid <= 1'b1;
          r_state     <= ST_DONE;
        end
        ST_DONE: begin
          if (bus.res_ready) begin
            r_last_grant <= r_res_id;
            r_res_valid  <= 1'b0;
            r_busy       <= 1'b0;
            r_state      <= ST_IDLE;
          end
        end
        default: begin
          r_res_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.a_ready   = w_a_ready;
  assign bus.b_ready   = w_b_ready;
  assign bus.res_valid = r_res_valid;
  assign bus.res_id    = r_res_id;
  assign bus.res_data  = r_res_data;
  assign bus.busy      = r_busy;
`ifdef ALU32_ARB_ZERO_FLAG_EN
  assign bus.res_zero  = r_res_zero;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu32_arbiter.sv
//------------------------------------------------------------------------------
// Module      : tb_alu32_arbiter
// Description : Self-checking bench for alu32_arbiter with a result
//               scoreboard. Honours ALU32_ARB_ZERO_FLAG_EN when defined.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_alu32_arbiter;

  logic clk;
  logic rst;

  alu32_arbiter_if #(.WIDTH(32)) bus ();

  alu32_arbiter #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct packed {
    logic        id;
    logic [31:0] data;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Pop the scoreboard whenever the consumer takes a result
  always @(negedge clk) begin
    if (!rst && bus.res_valid && bus.res_ready) begin
      if (sb_q.size() == 0) begin
        check_eq("unexpected_result", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check_eq("res_id", {31'd0, bus.res_id}, {31'd0, mon_e.id});
        check_eq("res_data", bus.res_data, mon_e.data);
`ifdef ALU32_ARB_ZERO_FLAG_EN
        check_eq("res_zero", {31'd0, bus.res_zero}, {31'd0, (mon_e.data == 32'd0)});
`endif
      end
    end
  end

  function automatic logic [31:0] alu_model(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
    case (op)
      2'b00:   return x & y;
      2'b01:   return x | y;
      2'b10:   return x ^ y;
      default: return x + y;
    endcase
  endfunction

  task automatic push_exp(input logic id, input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    e.id   = id;
    e.data = alu_model(op, x, y);
    sb_q.push_back(e);
  endtask

  // Keep each requester valid until it has completed the requested number of handshakes
  task automatic issue(input int na, input int nb, input int budget);
    int la = na;
    int lb = nb;
    int n  = 0;
    bus.a_valid = (la > 0);
    bus.b_valid = (lb > 0);
    while ((la > 0 || lb > 0) && n < budget) begin
      @(negedge clk);
      check_eq("ready_mutex", {31'd0, bus.a_ready & bus.b_ready}, 32'd0);
      if (bus.a_valid && bus.a_ready) la--;
      if (bus.b_valid && bus.b_ready) lb--;
      @(posedge clk); #1;
      bus.a_valid = (la > 0);
      bus.b_valid = (lb > 0);
      n++;
    end
    if (la > 0 || lb > 0) check_eq("issue_timeout", la + lb, 32'd0);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb_q.size() > 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb_q.size() > 0) check_eq("drain_timeout", sb_q.size(), 32'd0);
  endtask

  initial begin
    rst           = 1'b1;
    bus.a_valid   = 1'b1;
    bus.a_op      = 2'b00;
    bus.a_in1     = 32'd0;
    bus.a_in2     = 32'd0;
    bus.b_valid   = 1'b1;
    bus.b_op      = 2'b00;
    bus.b_in1     = 32'd0;
    bus.b_in2     = 32'd0;
    bus.res_ready = 1'b1;

    // Reset: no ready even with both requesting
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    check_eq("rst_a_ready", {31'd0, bus.a_ready}, 32'd0);
    check_eq("rst_b_ready", {31'd0, bus.b_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    @(negedge clk);
    check_eq("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
    check_eq("rst_res_id", {31'd0, bus.res_id}, 32'd0);
    check_eq("rst_res_data", bus.res_data, 32'd0);
    check_eq("rst_busy", {31'd0, bus.busy}, 32'd0);
`ifdef ALU32_ARB_ZERO_FLAG_EN
    check_eq("rst_res_zero", {31'd0, bus.res_zero}, 32'd1);
`endif
    @(posedge clk); #1;

    // Tie and fairness: A wins first after reset, then alternation
    bus.a_op = 2'b11; bus.a_in1 = 32'hFFFF_FFFF; bus.a_in2 = 32'h0000_0001;
    bus.b_op = 2'b01; bus.b_in1 = 32'h0000_0001; bus.b_in2 = 32'h0000_0002;
    push_exp(1'b0, 2'b11, 32'hFFFF_FFFF, 32'h0000_0001);
    push_exp(1'b1, 2'b01, 32'h0000_0001, 32'h0000_0002);
    push_exp(1'b0, 2'b11, 32'hFFFF_FFFF, 32'h0000_0001);
    push_exp(1'b1, 2'b01, 32'h0000_0001, 32'h0000_0002);
    issue(2, 2, 40);
    drain(20);

    // Single request with latency check
    bus.res_ready = 1'b0;
    bus.a_op = 2'b10; bus.a_in1 = 32'hF0F0_F0F0; bus.a_in2 = 32'hFFFF_0000;
    push_exp(1'b0, 2'b10, 32'hF0F0_F0F0, 32'hFFFF_0000);
    bus.a_valid = 1'b1;
    @(negedge clk);
    check_eq("single_a_ready", {31'd0, bus.a_ready}, 32'd1);
    check_eq("single_b_ready", {31'd0, bus.b_ready}, 32'd0);
    @(posedge clk); #1;
    bus.a_valid = 1'b0;
    @(negedge clk);
    check_eq("exec_a_ready", {31'd0, bus.a_ready}, 32'd0);
    check_eq("exec_res_valid", {31'd0, bus.res_valid}, 32'd0);
    check_eq("exec_busy", {31'd0, bus.busy}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("single_res_valid", {31'd0, bus.res_valid}, 32'd1);
    check_eq("single_res_id", {31'd0, bus.res_id}, 32'd0);
    check_eq("single_res_data", bus.res_data, 32'h0F0F_F0F0);
    @(posedge clk); #1;
    bus.res_ready = 1'b1;
    drain(10);

    // Backpressure on a B result while A waits, then operand change after accept
    bus.res_ready = 1'b0;
    bus.b_op = 2'b00; bus.b_in1 = 32'h1234_5678; bus.b_in2 = 32'h0000_FFFF;
    push_exp(1'b1, 2'b00, 32'h1234_5678, 32'h0000_FFFF);
    issue(0, 1, 10);
    bus.a_op = 2'b10; bus.a_in1 = 32'hAAAA_5555; bus.a_in2 = 32'hFFFF_FFFF;
    push_exp(1'b0, 2'b10, 32'hAAAA_5555, 32'hFFFF_FFFF);
    bus.a_valid = 1'b1;
    @(negedge clk);
    check_eq("bp_exec_a_ready", {31'd0, bus.a_ready}, 32'd0);
    @(posedge clk); #1;
    repeat (5) begin
      @(negedge clk);
      check_eq("bp_res_valid", {31'd0, bus.res_valid}, 32'd1);
      check_eq("bp_res_id", {31'd0, bus.res_id}, 32'd1);
      check_eq("bp_res_data", bus.res_data, 32'h0000_5678);
      check_eq("bp_readies", {30'd0, bus.a_ready, bus.b_ready}, 32'd0);
      @(posedge clk); #1;
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    check_eq("no_same_cycle_grant", {31'd0, bus.a_ready}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("grant_after_done", {31'd0, bus.a_ready}, 32'd1);
    @(posedge clk); #1;
    bus.a_valid = 1'b0;
    bus.a_in1   = 32'd0;
    bus.a_in2   = 32'd0;
    drain(10);

    // Reset in EXEC discards the operation; afterwards A wins the tie
    bus.a_op = 2'b11; bus.a_in1 = 32'h10; bus.a_in2 = 32'h20;
    bus.a_valid = 1'b1;
    @(negedge clk);
    check_eq("pre_reset_grant", {31'd0, bus.a_ready}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    bus.a_op = 2'b00; bus.a_in1 = 32'hFFFF_FFFF; bus.a_in2 = 32'h1234_5678;
    bus.b_op = 2'b11; bus.b_in1 = 32'h7FFF_FFFF; bus.b_in2 = 32'h0000_0001;
    bus.b_valid = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("mid_rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
    check_eq("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("mid_rst_res_data", bus.res_data, 32'd0);
    check_eq("mid_rst_res_id", {31'd0, bus.res_id}, 32'd0);
    check_eq("mid_rst_readies", {30'd0, bus.a_ready, bus.b_ready}, 32'd0);
`ifdef ALU32_ARB_ZERO_FLAG_EN
    check_eq("mid_rst_res_zero", {31'd0, bus.res_zero}, 32'd1);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    push_exp(1'b0, 2'b00, 32'hFFFF_FFFF, 32'h1234_5678);
    push_exp(1'b1, 2'b11, 32'h7FFF_FFFF, 32'h0000_0001);
    issue(1, 1, 20);
    drain(20);

    // Idle noise: res_ready high with nothing requested
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    bus.res_ready = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check_eq("idle_res_valid", {31'd0, bus.res_valid}, 32'd0);
      check_eq("idle_busy", {31'd0, bus.busy}, 32'd0);
      @(posedge clk); #1;
    end

    check_eq("sb_empty", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu32_arbiter.md
# alu32_arbiter

Round-robin arbiter and sequencer that shares one 32-bit ALU datapath (AND/OR/XOR/ADD) between two requesters. It accepts one operation at a time over a valid/ready handshake, registers the operands, evaluates them in a dedicated execute cycle and holds the tagged result until the consumer accepts it. It sits between the two issuing units and the ALU32 logic slices, and is the only path by which operations reach them.

## Interface
Parameters:
- WIDTH, 32, operand/result width; the ALU slices are 32-bit, so only 32 is supported.

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- a_valid  input  1  requester A holds a valid operation
- a_ready  output  1  requester A's operation is accepted this cycle
- a_op  input  2  A opcode: 00 AND, 01 OR, 10 XOR, 11 ADD
- a_in1, a_in2  input  WIDTH  A operands
- b_valid, b_ready, b_op, b_in1, b_in2  same as the A ports, for requester B
- res_valid  output  1  result register is valid
- res_ready  input  1  consumer accepts the result
- res_id  output  1  0 = result belongs to A, 1 = result belongs to B
- res_data  output  WIDTH  result
- busy  output  1  high in EXEC or DONE
- res_zero  output  1  res_data == 0; present only with ALU32_ARB_ZERO_FLAG_EN

## Operation
- FSM states are IDLE, EXEC and DONE; the encoding is free.
- IDLE:
  - If only one valid is high, that requester is granted.
  - If both are high, grant the requester that is not last_grant.
  - Grant is combinational: x_ready = (state==IDLE) && grant==x. At most one ready is high.
  - On handshake, latch op, in1, in2 and id into operand registers, then go to EXEC.
- EXEC: compute the result from the latched operands into res_data and go to DONE. Requester inputs are ignored.
- Arithmetic:
  - AND, OR and XOR are bitwise.
  - ADD is the modulo-2^32 sum; carry-out is discarded (0xFFFFFFFF + 1 = 0).
- DONE: res_valid=1.
  - res_data and res_id stay stable until res_ready.
  - On res_valid && res_ready: last_grant <= res_id, go to IDLE.
- last_grant updates only at result acceptance, not at grant.
- Requester inputs that change after the handshake have no effect on the in-flight operation.
- A requester whose valid drops while it is not granted loses nothing. No request is queued.

## Timing
- Reset values: state=IDLE, last_grant=B (A wins the first tie), res_valid=0, res_id=0, res_data=0, busy=0, res_zero=1 (when present).
- a_ready and b_ready are 0 during reset and whenever state is not IDLE.
- Latency: handshake at edge N, then res_valid is high from cycle N+2.
- Throughput: at best one operation per 3 cycles, achieved when res_ready is tied high.
- DONE to IDLE happens on the accepting edge. A new grant is possible in the following cycle, not in the same cycle.
- rst in any state:
  - The in-flight operation is discarded, with no result and no ready.
  - Next cycle is IDLE with reset values.
  - rst has priority over a simultaneous handshake or result acceptance.
- res_ready asserted while res_valid=0 is ignored.

## Configuration
- ALU32_ARB_ZERO_FLAG_EN defined:
  - The res_zero port exists.
  - It is registered alongside res_data in EXEC and is valid whenever res_valid=1.
  - Reset value is 1.
- Not defined: no res_zero port and no flag logic. All other behaviour is identical.

## Test plan
- Single request: a_valid=1, a_op=10, a_in1=0xF0F0F0F0, a_in2=0xFFFF0000. Expect a_ready=1 for one cycle, then 2 cycles later res_valid=1, res_id=0, res_data=0x0F0FF0F0.
- Tie and fairness: both valid continuously, res_ready=1, A ADD 0xFFFFFFFF+1, B OR 0x1+0x2. Expect results in order A(0x00000000, res_zero=1 if enabled), B(0x3), A, B.
- Backpressure: B AND 0x12345678 & 0x0000FFFF with res_ready=0 for 5 cycles. Expect res_data=0x00005678 stable and both readies 0 throughout; after res_ready=1, IDLE follows and a grant is possible the next cycle.
- Operand change after accept: after the handshake, drive a_in1 to 0 while the operation is in flight. Expect res_data computed from the original latched operands.
- Reset mid-operation: assert rst in EXEC. Expect no res_valid and all outputs at reset values. After release, with both valid, A is granted first.
- Idle noise: res_ready=1 with no requests for 10 cycles. Expect res_valid=0, busy=0 and no state change.
